// File: rtl/htree_read_return_16.sv
// Read-return gather stage for the 16-way H-tree.
// It snoops the host request stream and tracks reads in a tag pipeline sized
// to the fanout plus SRAM latency. Returning words pass through a registered
// two-level 4:1 select tree and are then buffered in a registered FIFO with
// credit-based issue control.
// Optional feature macro: HTREE_RET_PARITY_EN. When it is defined, the block
// adds per-bank parity select, a stored per-entry parity bit and a sticky
// parity error flag.
module htree_read_return_16 #(
  parameter int BusWidth   = 32,
  parameter int FANOUT_LAT = 3,
  parameter int SRAM_LAT   = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_en,
  input  logic                   req_we,
  input  logic [11:0]            req_addr,
  output logic                   req_ready,
  input  logic [16*BusWidth-1:0] bank_rdata,
`ifdef HTREE_RET_PARITY_EN
  input  logic [15:0]            bank_par,
  output logic                   rd_parity,
  output logic                   err_parity,
`endif
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [BusWidth-1:0]    rd_data,
  output logic [3:0]             rd_bank,
  output logic                   err_overflow
);

  localparam int Lat  = FANOUT_LAT + SRAM_LAT;
  localparam int CntW = $clog2(FIFO_DEPTH + 1);
  localparam int PtrW = $clog2(FIFO_DEPTH);

  logic                read_req;
  logic                accept;
  logic                push;
  logic                pop;
  logic [CntW-1:0]     inflight;
  logic [CntW-1:0]     count;
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;

  logic [Lat-1:0]      tag_vld;
  logic [3:0]          tag_id [Lat];

  logic [BusWidth-1:0] s1_sel  [4];
  logic [BusWidth-1:0] s1_data [4];
  logic                s1_vld;
  logic [3:0]          s1_id;

  logic [BusWidth-1:0] s2_data;
  logic                s2_vld;
  logic [3:0]          s2_id;

  logic [BusWidth-1:0] fifo_data [FIFO_DEPTH];
  logic [3:0]          fifo_bank [FIFO_DEPTH];

  // Only bank-select bits of the address matter to the return path.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^req_addr[7:0];

  assign read_req  = req_en && !req_we;
  assign req_ready = !RST && (inflight < CntW'(FIFO_DEPTH));
  assign accept    = read_req && req_ready;
  assign pop       = rd_valid && rd_ready;
  // An untracked push into a full FIFO can only come from a credit violation; drop it.
  assign push      = s2_vld && ((count != CntW'(FIFO_DEPTH)) || pop);

  // Tag valid shift pipeline, aligned with fanout + SRAM latency.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= accept;
      for (int i = 1; i < Lat; i++) tag_vld[i] <= tag_vld[i-1];
    end
  end

  // Tag bank-id shift pipeline (payload only, qualified by tag_vld).
  always_ff @(posedge CLK) begin
    tag_id[0] <= req_addr[11:8];
    for (int i = 1; i < Lat; i++) tag_id[i] <= tag_id[i-1];
  end

  // First-level quadrant selects, driven by the emerging tag's low bank bits.
  always_comb begin
    // NOTE: defaults first so that every path assigns each output and no latch is inferred.
    for (int q = 0; q < 4; q++) s1_sel[q] = '0;
    for (int q = 0; q < 4; q++) begin
      s1_sel[q] = bank_rdata[(q*4 + int'(tag_id[Lat-1][1:0]))*BusWidth +: BusWidth];
    end
  end

  // Stage 1 and stage 2 valid flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= tag_vld[Lat-1];
      s2_vld <= s1_vld;
    end
  end

  // Stage 1 and stage 2 data registers; the quadrant bits pick the final word.
  always_ff @(posedge CLK) begin
    s1_data <= s1_sel;
    s1_id   <= tag_id[Lat-1];
    s2_data <= s1_data[s1_id[3:2]];
    s2_id   <= s1_id;
  end

  // FIFO pointers and occupancy; pointers wrap modulo the power-of-two depth.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; pointers and count define validity and the outputs are gated by rd_valid.
    if (push) begin
      fifo_data[wr_ptr] <= s2_data;
      fifo_bank[wr_ptr] <= s2_id;
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? fifo_data[rd_ptr] : '0;
  assign rd_bank  = rd_valid ? fifo_bank[rd_ptr] : '0;

  // Credit counter: reads accepted but not yet popped by the host.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight <= inflight + CntW'(1);
        2'b01:   inflight <= inflight - CntW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky flag for a read issued without credit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_overflow <= 1'b0;
    end else if (read_req && !req_ready) begin
      err_overflow <= 1'b1;
    end
  end

`ifdef HTREE_RET_PARITY_EN
  logic       s1_par_sel [4];
  logic       s1_par     [4];
  logic       s2_par;
  logic       fifo_par   [FIFO_DEPTH];

  // Parity bits follow the same quadrant select as the data.
  always_comb begin
    for (int q = 0; q < 4; q++) s1_par_sel[q] = 1'b0;
    for (int q = 0; q < 4; q++) begin
      s1_par_sel[q] = bank_par[q*4 + int'(tag_id[Lat-1][1:0])];
    end
  end

  // Parity carried alongside the stage 1 and stage 2 data.
  always_ff @(posedge CLK) begin
    s1_par <= s1_par_sel;
    s2_par <= s1_par[s1_id[3:2]];
  end

  // Parity is recomputed from the word as it is written and stored per entry.
  always_ff @(posedge CLK) begin
    if (push) fifo_par[wr_ptr] <= ^s2_data;
  end

  // Sticky error when the recomputed parity disagrees with the bank's parity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_parity <= 1'b0;
    end else if (push && ((^s2_data) != s2_par)) begin
      err_parity <= 1'b1;
    end
  end

  assign rd_parity = rd_valid ? fifo_par[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_htree_read_return_16.sv
// Self-checking bench for htree_read_return_16.
// A transaction-level model predicts the return order, the data and the
// timing, as well as the credit and overflow flags. It is compared against the
// DUT on every cycle. Directed tests add literal expectations.
module tb_htree_read_return_16;

  localparam int BW    = 32;
  localparam int LAT   = 4;   // fanout + SRAM latency
  localparam int DEPTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             req_en = 1'b0;
  logic             req_we = 1'b0;
  logic [11:0]      req_addr = '0;
  logic             req_ready;
  logic [16*BW-1:0] bank_rdata;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [BW-1:0]    rd_data;
  logic [3:0]       rd_bank;
  logic             err_overflow;

  logic [31:0]      bank_word [16];

  int n_checks = 0;
  int n_err    = 0;

  htree_read_return_16 dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_en       (req_en),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .bank_rdata   (bank_rdata),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_bank      (rd_bank),
    .err_overflow (err_overflow)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    bank_rdata = '0;
    for (int n = 0; n < 16; n++) bank_rdata[n*BW +: BW] = bank_word[n];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [3:0]  bank;
    int          acc_edge;
    int          ready_edge;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   e_cnt      = 0;
  int   inflight_m = 0;
  bit   err_m      = 1'b0;
  bit   started    = 1'b0;

  // A tracked read accepted at edge e samples its bank at edge e+LAT and is
  // visible at the head from edge e+LAT+2 onward, and it leaves on a pop.
  always @(posedge CLK) begin
    bit   pop_m;
    bit   ready_m;
    ent_t t;
    e_cnt++;
    started = 1'b1;
    if (RST) begin
      q.delete();
      inflight_m = 0;
      err_m      = 1'b0;
    end else begin
      pop_m   = (q.size() > 0) && (q[0].ready_edge < e_cnt) && rd_ready;
      ready_m = inflight_m < DEPTH;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].acc_edge + LAT == e_cnt) begin
          t = q[i];
          t.data = bank_word[t.bank];
          q[i] = t;
        end
      end
      if (pop_m) begin
        void'(q.pop_front());
        inflight_m--;
      end
      if (req_en && !req_we) begin
        if (ready_m) begin
          t.bank       = req_addr[11:8];
          t.acc_edge   = e_cnt;
          t.ready_edge = e_cnt + LAT + 2;
          t.data       = 'x;
          q.push_back(t);
          inflight_m++;
        end else begin
          err_m = 1'b1;
        end
      end
    end
  end

  // Pop log of what the DUT actually delivered.
  logic [3:0]  pop_bank [256];
  logic [31:0] pop_data [256];
  int          pop_edge [256];
  int          pop_cnt = 0;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge CLK) begin
    bit exp_valid;
    if (started) begin
      exp_valid = (q.size() > 0) && (q[0].ready_edge <= e_cnt);
      check("rd_valid", rd_valid, exp_valid);
      check("req_ready", req_ready, (!RST && inflight_m < DEPTH));
      check("err_overflow", err_overflow, err_m);
      if (exp_valid) begin
        check("rd_data", rd_data, q[0].data);
        check("rd_bank", rd_bank, q[0].bank);
      end
      if (rd_valid && rd_ready && pop_cnt < 256) begin
        pop_bank[pop_cnt] = rd_bank;
        pop_data[pop_cnt] = rd_data;
        pop_edge[pop_cnt] = e_cnt;
        pop_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic [11:0] addr);
    req_en   = en;
    req_we   = we;
    req_addr = addr;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    logic [11:0] addrs [4];
    logic [3:0]  exp_banks [4];

    for (int n = 0; n < 16; n++) bank_word[n] = 32'hB000_0000 | (32'(n) << 16);

    // Reset state
    repeat (3) step();
    check("reset rd_valid", rd_valid, 1'b0);
    check("reset rd_data", rd_data, 32'h0);
    check("reset rd_bank", rd_bank, 4'h0);
    check("reset err_overflow", err_overflow, 1'b0);
    check("reset req_ready", req_ready, 1'b0);
    RST = 1'b0;
    #1;
    check("ready after reset", req_ready, 1'b1);

    // Single read of bank 3, latency 7
    bank_word[3] = 32'hDEAD_BEEF;
    drive(1'b1, 1'b0, 12'h300);
    step();
    drive(1'b0, 1'b0, 12'h000);
    repeat (5) step();
    check("t1 not early", rd_valid, 1'b0);
    step();
    check("t1 valid", rd_valid, 1'b1);
    check("t1 data", rd_data, 32'hDEAD_BEEF);
    check("t1 bank", rd_bank, 4'd3);
    step();
    check("t1 held", rd_data, 32'hDEAD_BEEF);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t1 popped", rd_valid, 1'b0);

    // Back-to-back reads to banks 0, 5, 10, 15
    for (int n = 0; n < 16; n++) bank_word[n] = 32'hA5A5_0000 + 32'(n) * 32'h0000_0101;
    addrs     = '{12'h000, 12'h500, 12'hA00, 12'hF00};
    exp_banks = '{4'd0, 4'd5, 4'd10, 4'd15};
    rd_ready = 1'b1;
    base = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, addrs[i]);
      step();
    end
    drive(1'b0, 1'b0, 12'h000);
    repeat (10) step();
    check("t2 pop count", pop_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2 bank order", pop_bank[base+i], exp_banks[i]);
      check("t2 data", pop_data[base+i], 32'hA5A5_0000 + 32'(exp_banks[i]) * 32'h0000_0101);
      check("t2 consecutive", pop_edge[base+i], pop_edge[base] + i);
    end

    // Fill credits with rd_ready low
    rd_ready = 1'b0;
    for (int n = 0; n < 16; n++) bank_word[n] = 32'h5000_0000 | 32'(n);
    for (int i = 0; i < 8; i++) begin
      check("t3 ready before accept", req_ready, 1'b1);
      drive(1'b1, 1'b0, 12'(i * 256));
      step();
    end
    drive(1'b0, 1'b0, 12'h000);
    check("t3 ready after 8", req_ready, 1'b0);

    // Ninth read while out of credit
    drive(1'b1, 1'b0, 12'h900);
    step();
    drive(1'b0, 1'b0, 12'h000);
    check("t4 overflow set", err_overflow, 1'b1);
    repeat (10) step();
    check("t4 overflow sticky", err_overflow, 1'b1);
    check("t4 still full", req_ready, 1'b0);
    base = pop_cnt;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t3 ready after one pop", req_ready, 1'b1);
    rd_ready = 1'b1;
    repeat (12) step();
    check("t4 exactly 8 returned", pop_cnt - base, 8);
    for (int i = 0; i < 8; i++) check("t4 bank order", pop_bank[base+i], 4'(i));
    check("t4 overflow after drain", err_overflow, 1'b1);

    // Writes interleaved with two reads
    base = pop_cnt;
    drive(1'b1, 1'b0, 12'h100); check("t5 ready", req_ready, 1'b1); step();
    drive(1'b1, 1'b1, 12'h200); check("t5 ready", req_ready, 1'b1); step();
    drive(1'b1, 1'b1, 12'h300); check("t5 ready", req_ready, 1'b1); step();
    drive(1'b1, 1'b0, 12'h400); check("t5 ready", req_ready, 1'b1); step();
    drive(1'b1, 1'b1, 12'h500); check("t5 ready", req_ready, 1'b1); step();
    drive(1'b0, 1'b0, 12'h000);
    repeat (12) step();
    check("t5 two returns", pop_cnt - base, 2);
    check("t5 first bank", pop_bank[base], 4'd1);
    check("t5 second bank", pop_bank[base+1], 4'd4);

    // Reset with three reads in flight
    base = pop_cnt;
    drive(1'b1, 1'b0, 12'h600); step();
    drive(1'b1, 1'b0, 12'h700); step();
    drive(1'b1, 1'b0, 12'h800); step();
    drive(1'b0, 1'b0, 12'h000);
    step();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    #1;
    check("t6 ready after reset", req_ready, 1'b1);
    check("t6 overflow cleared", err_overflow, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t6 no output", rd_valid, 1'b0);
      step();
    end
    check("t6 nothing popped", pop_cnt - base, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
